// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU op codes, operand/result
// selects, instruction opcodes and funct codes, and the decoded control bundle.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_N  = 32;

  typedef enum logic [3:0] {
    ALU_AND   = 4'h0,
    ALU_OR    = 4'h1,
    ALU_XOR   = 4'h2,
    ALU_NOR   = 4'h3,
    ALU_ADD   = 4'h4,
    ALU_SUB   = 4'h5,
    ALU_SLT   = 4'h6,
    ALU_SLTU  = 4'h7,
    ALU_SLL   = 4'h8,
    ALU_SRL   = 4'h9,
    ALU_SRA   = 4'hA,
    ALU_MULT  = 4'hB,
    ALU_MULTU = 4'hC,
    ALU_NOP   = 4'hD
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_RT   = 2'd0,
    SRC_SEXT = 2'd1,
    SRC_ZEXT = 2'd2
  } alu_src_e;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_HI   = 2'd1,
    SEL_LO   = 2'd2,
    SEL_GPIO = 2'd3
  } regsel_e;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_GPIO_RD = 6'h1E;
  localparam logic [5:0] OP_GPIO_WR = 6'h1F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef struct packed {
    alu_op_e    alu_op;
    alu_src_e   alu_src;
    regsel_e    regsel;
    logic [4:0] shamt;
    logic       rdrt;
    logic       regwrite;
    logic       enhilo;
    logic       gpio_out_en;
    logic       gpio_in_en;
  } ctrl_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// r0 hardwired to zero, asynchronous clear of every entry.
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [REG_N];
  logic              w_wr_ok;

  assign w_wr_ok = i_we && (i_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A write landing this cycle is visible to the same-cycle read.
  assign o_rdata_a = (i_raddr_a == '0) ? '0 :
                     (w_wr_ok && i_waddr == i_raddr_a) ? i_wdata : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 :
                     (w_wr_ok && i_waddr == i_raddr_b) ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/mips_exec_unit.sv
// Execute stage of the two-stage MIPS pipeline: decoder, register file,
// ALU with 32x32 multiplier, HI/LO registers and writeback result mux.
module mips_exec_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] gpio_in,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] alu_hi,
  output logic              zero,
  output logic              regwrite,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              memwrite,
  output logic              gpio_out_en,
  output logic              gpio_in_en
);

  ctrl_t                    w_ctrl;
  logic [5:0]               w_opcode;
  logic [5:0]               w_funct;
  logic [15:0]              w_imm;
  logic [DATA_W-1:0]        w_b;
  logic signed [DATA_W-1:0] w_a_s;
  logic signed [DATA_W-1:0] w_b_s;
  logic [2*DATA_W-1:0]      w_prod_s;
  logic [2*DATA_W-1:0]      w_prod_u;
  logic [DATA_W-1:0]        w_lo;
  logic [DATA_W-1:0]        w_hi;
  logic [DATA_W-1:0]        r_hi;
  logic [DATA_W-1:0]        r_lo;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_imm    = instr[15:0];

  mips_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (instr[25:21]),
    .i_raddr_b (instr[20:16]),
    .o_rdata_a (rs_data),
    .o_rdata_b (rt_data)
  );

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_NOP;
    w_ctrl.shamt  = instr[10:6];
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.regwrite = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl.alu_op = ALU_SUB;
          FN_AND:          w_ctrl.alu_op = ALU_AND;
          FN_OR:           w_ctrl.alu_op = ALU_OR;
          FN_XOR:          w_ctrl.alu_op = ALU_XOR;
          FN_NOR:          w_ctrl.alu_op = ALU_NOR;
          FN_SLT:          w_ctrl.alu_op = ALU_SLT;
          FN_SLTU:         w_ctrl.alu_op = ALU_SLTU;
          FN_SLL:          w_ctrl.alu_op = ALU_SLL;
          FN_SRL:          w_ctrl.alu_op = ALU_SRL;
          FN_SRA:          w_ctrl.alu_op = ALU_SRA;
          FN_MFHI:         w_ctrl.regsel = SEL_HI;
          FN_MFLO:         w_ctrl.regsel = SEL_LO;
          FN_MULT: begin
            w_ctrl.alu_op   = ALU_MULT;
            w_ctrl.enhilo   = 1'b1;
            w_ctrl.regwrite = 1'b0;
          end
          FN_MULTU: begin
            w_ctrl.alu_op   = ALU_MULTU;
            w_ctrl.enhilo   = 1'b1;
            w_ctrl.regwrite = 1'b0;
          end
          default:         w_ctrl.regwrite = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_ctrl.rdrt     = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alu_src  = SRC_SEXT;
        w_ctrl.alu_op   = (w_opcode == OP_SLTI)  ? ALU_SLT  :
                          (w_opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_ctrl.rdrt     = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.alu_src  = SRC_ZEXT;
        w_ctrl.alu_op   = (w_opcode == OP_ANDI) ? ALU_AND :
                          (w_opcode == OP_ORI)  ? ALU_OR  :
                          (w_opcode == OP_XORI) ? ALU_XOR : ALU_SLL;
        if (w_opcode == OP_LUI) w_ctrl.shamt = 5'd16;
      end
      OP_GPIO_RD: begin
        w_ctrl.rdrt       = 1'b1;
        w_ctrl.regwrite   = 1'b1;
        w_ctrl.regsel     = SEL_GPIO;
        w_ctrl.gpio_in_en = 1'b1;
      end
      OP_GPIO_WR: w_ctrl.gpio_out_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (w_ctrl.alu_src)
      SRC_SEXT: w_b = {{16{w_imm[15]}}, w_imm};
      SRC_ZEXT: w_b = {16'h0000, w_imm};
      default:  w_b = rt_data;
    endcase
  end

  assign w_a_s    = rs_data;
  assign w_b_s    = w_b;
  assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{w_b[31]}}, w_b};
  assign w_prod_u = {32'h0, rs_data} * {32'h0, w_b};

  always_comb begin
    w_hi = '0;
    w_lo = '0;
    case (w_ctrl.alu_op)
      ALU_AND:   w_lo = rs_data & w_b;
      ALU_OR:    w_lo = rs_data | w_b;
      ALU_XOR:   w_lo = rs_data ^ w_b;
      ALU_NOR:   w_lo = ~(rs_data | w_b);
      ALU_ADD:   w_lo = rs_data + w_b;
      ALU_SUB:   w_lo = rs_data - w_b;
      ALU_SLT:   w_lo = {31'h0, (w_a_s < w_b_s)};
      ALU_SLTU:  w_lo = {31'h0, (rs_data < w_b)};
      ALU_SLL:   w_lo = w_b << w_ctrl.shamt;
      ALU_SRL:   w_lo = w_b >> w_ctrl.shamt;
      ALU_SRA:   w_lo = $unsigned(w_b_s >>> w_ctrl.shamt);
      ALU_MULT:  {w_hi, w_lo} = w_prod_s;
      ALU_MULTU: {w_hi, w_lo} = w_prod_u;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_ctrl.enhilo) begin
      r_hi <= w_hi;
      r_lo <= w_lo;
    end
  end

  always_comb begin
    case (w_ctrl.regsel)
      SEL_HI:   result = r_hi;
      SEL_LO:   result = r_lo;
      SEL_GPIO: result = gpio_in;
      default:  result = w_lo;
    endcase
  end

  assign alu_hi      = w_hi;
  assign zero        = (w_lo == '0);
  assign regwrite    = w_ctrl.regwrite;
  assign dest_addr   = w_ctrl.rdrt ? instr[20:16] : instr[15:11];
  assign memwrite    = 1'b0;
  assign gpio_out_en = w_ctrl.gpio_out_en;
  assign gpio_in_en  = w_ctrl.gpio_in_en;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed vector bench for mips_exec_unit: a sequential table of instructions
// and writeback requests, followed by hand-written mid-operation reset checks.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] gpio_in;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs_data, rt_data, result, alu_hi;
  logic        zero, regwrite, memwrite, gpio_out_en, gpio_in_en;
  logic [4:0]  dest_addr;

  int n_cmp = 0;
  int n_err = 0;

  mips_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .gpio_in     (gpio_in),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .result      (result),
    .alu_hi      (alu_hi),
    .zero        (zero),
    .regwrite    (regwrite),
    .dest_addr   (dest_addr),
    .memwrite    (memwrite),
    .gpio_out_en (gpio_out_en),
    .gpio_in_en  (gpio_in_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] gpio;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [1:0]  chk;   // {check result, check zero}
    logic [31:0] res;
    logic        zero;
    logic [31:0] hi;
    logic [4:0]  dest;
    logic        rw;
    logic        goe;
    logic        gie;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    logic [4:0] a, b, d, s;
    a = rs[4:0]; b = rt[4:0]; d = rd[4:0]; s = sh[4:0];
    return {6'h00, a, b, d, s, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    logic [4:0] a, b;
    a = rs[4:0]; b = rt[4:0];
    return {op, a, b, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] gp,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [1:0] chk,
                              input logic [31:0] res, input logic z, input logic [31:0] hi,
                              input logic [4:0] dest, input logic rw, input logic goe,
                              input logic gie);
    vec_t v;
    v.instr = ins; v.we = we; v.wa = wa; v.wd = wd; v.gpio = gp;
    v.rs = rs; v.rt = rt; v.chk = chk; v.res = res; v.zero = z; v.hi = hi;
    v.dest = dest; v.rw = rw; v.goe = goe; v.gie = gie;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // instr              we wa  wd          gpio   rs          rt          chk    res         z     hi          dest rw goe gie
    tbl.push_back(mk(enc_r(1,2,3,0,6'h20),   0, 0, 0,          0,     0,          0,          2'b11, 0,          1'b1, 0,          3,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h10),   0, 0, 0,          0,     0,          0,          2'b10, 0,          1'b0, 0,          4,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h12),   0, 0, 0,          0,     0,          0,          2'b10, 0,          1'b0, 0,          4,  1, 0, 0));
    tbl.push_back(mk(enc_i(6'h08,5,6,16'h0020), 1, 5, 32'hFFFF_FFF0, 0, 32'hFFFF_FFF0, 0,     2'b11, 32'h10,     1'b0, 0,          6,  1, 0, 0));
    tbl.push_back(mk(enc_i(6'h3B,5,0,16'h0), 1, 1, 32'hFFFF_FFFF, 0,  32'hFFFF_FFF0, 0,       2'b00, 0,          1'b0, 0,          0,  0, 0, 0));
    tbl.push_back(mk(enc_i(6'h3B,1,0,16'h0), 1, 2, 2,          0,     32'hFFFF_FFFF, 0,       2'b00, 0,          1'b0, 0,          0,  0, 0, 0));
    tbl.push_back(mk(enc_r(1,2,0,0,6'h18),   1, 3, 32'h8000_0000, 0,  32'hFFFF_FFFF, 2,       2'b11, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 0, 0, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h10),   0, 0, 0,          0,     0,          0,          2'b10, 32'hFFFF_FFFF, 1'b0, 0,       4,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h12),   0, 0, 0,          0,     0,          0,          2'b10, 32'hFFFF_FFFE, 1'b0, 0,       4,  1, 0, 0));
    tbl.push_back(mk(enc_r(1,2,0,0,6'h19),   0, 0, 0,          0,     32'hFFFF_FFFF, 2,       2'b11, 32'hFFFF_FFFE, 1'b0, 1,       0,  0, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h10),   0, 0, 0,          0,     0,          0,          2'b10, 1,          1'b0, 0,          4,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h12),   0, 0, 0,          0,     0,          0,          2'b10, 32'hFFFF_FFFE, 1'b0, 0,       4,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,3,7,4,6'h03),   0, 0, 0,          0,     0,          32'h8000_0000, 2'b11, 32'hF800_0000, 1'b0, 0,    7,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,3,7,4,6'h02),   0, 0, 0,          0,     0,          32'h8000_0000, 2'b11, 32'h0800_0000, 1'b0, 0,    7,  1, 0, 0));
    tbl.push_back(mk(enc_i(6'h0F,0,8,16'h1234), 0, 0, 0,       0,     0,          0,          2'b11, 32'h1234_0000, 1'b0, 0,       8,  1, 0, 0));
    tbl.push_back(mk(enc_i(6'h0D,0,9,16'hFFFF), 0, 0, 0,       0,     0,          0,          2'b11, 32'h0000_FFFF, 1'b0, 0,       9,  1, 0, 0));
    tbl.push_back(mk(enc_i(6'h0C,1,10,16'h8001), 0, 0, 0,      0,     32'hFFFF_FFFF, 0,       2'b11, 32'h0000_8001, 1'b0, 0,       10, 1, 0, 0));
    tbl.push_back(mk(enc_r(1,2,10,0,6'h2A),  0, 0, 0,          0,     32'hFFFF_FFFF, 2,       2'b11, 1,          1'b0, 0,          10, 1, 0, 0));
    tbl.push_back(mk(enc_r(1,2,10,0,6'h2B),  0, 0, 0,          0,     32'hFFFF_FFFF, 2,       2'b11, 0,          1'b1, 0,          10, 1, 0, 0));
    tbl.push_back(mk(enc_r(2,2,11,0,6'h22),  0, 0, 0,          0,     2,          2,          2'b11, 0,          1'b1, 0,          11, 1, 0, 0));
    tbl.push_back(mk(enc_r(1,2,14,0,6'h26),  0, 0, 0,          0,     32'hFFFF_FFFF, 2,       2'b11, 32'hFFFF_FFFD, 1'b0, 0,       14, 1, 0, 0));
    tbl.push_back(mk(enc_r(3,2,14,0,6'h27),  0, 0, 0,          0,     32'h8000_0000, 2,       2'b11, 32'h7FFF_FFFD, 1'b0, 0,       14, 1, 0, 0));
    tbl.push_back(mk(enc_r(3,2,18,0,6'h25),  0, 0, 0,          0,     32'h8000_0000, 2,       2'b11, 32'h8000_0002, 1'b0, 0,       18, 1, 0, 0));
    tbl.push_back(mk(enc_r(1,3,18,0,6'h24),  0, 0, 0,          0,     32'hFFFF_FFFF, 32'h8000_0000, 2'b11, 32'h8000_0000, 1'b0, 0, 18, 1, 0, 0));
    tbl.push_back(mk(enc_r(2,1,18,0,6'h23),  0, 0, 0,          0,     2,          32'hFFFF_FFFF, 2'b11, 3,          1'b0, 0,          18, 1, 0, 0));
    tbl.push_back(mk(enc_r(5,2,18,0,6'h21),  0, 0, 0,          0,     32'hFFFF_FFF0, 2,       2'b11, 32'hFFFF_FFF2, 1'b0, 0,       18, 1, 0, 0));
    tbl.push_back(mk(enc_i(6'h0A,2,15,16'hFFFF), 0, 0, 0,      0,     2,          0,          2'b11, 0,          1'b1, 0,          15, 1, 0, 0));
    tbl.push_back(mk(enc_i(6'h0B,2,15,16'hFFFF), 0, 0, 0,      0,     2,          0,          2'b11, 1,          1'b0, 0,          15, 1, 0, 0));
    tbl.push_back(mk(enc_i(6'h09,2,16,16'hFFFE), 0, 0, 0,      0,     2,          0,          2'b11, 0,          1'b1, 0,          16, 1, 0, 0));
    tbl.push_back(mk(enc_i(6'h0E,2,19,16'h00FF), 0, 0, 0,      0,     2,          0,          2'b11, 32'h0000_00FD, 1'b0, 0,       19, 1, 0, 0));
    tbl.push_back(mk(enc_r(0,2,17,3,6'h00),  0, 0, 0,          0,     0,          2,          2'b11, 32'h10,     1'b0, 0,          17, 1, 0, 0));
    tbl.push_back(mk(enc_r(0,0,12,0,6'h20),  1, 0, 32'hDEAD_BEEF, 0,  0,          0,          2'b11, 0,          1'b1, 0,          12, 1, 0, 0));
    tbl.push_back(mk(enc_r(0,2,12,0,6'h20),  0, 0, 0,          0,     0,          2,          2'b11, 2,          1'b0, 0,          12, 1, 0, 0));
    tbl.push_back(mk(enc_i(6'h1E,0,13,16'h0), 0, 0, 0,  32'h0000_CAFE, 0,         0,          2'b10, 32'h0000_CAFE, 1'b0, 0,       13, 1, 0, 1));
    tbl.push_back(mk(enc_i(6'h1F,0,3,16'h0), 0, 0, 0,          0,     0,          32'h8000_0000, 2'b00, 0,       1'b0, 0,          0,  0, 1, 0));
    tbl.push_back(mk(enc_i(6'h3B,3,2,16'h0018), 0, 0, 0,       0,     32'h8000_0000, 2,       2'b00, 0,          1'b0, 0,          0,  0, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h10),   0, 0, 0,          0,     0,          0,          2'b10, 1,          1'b0, 0,          4,  1, 0, 0));
    tbl.push_back(mk(enc_r(0,0,4,0,6'h12),   0, 0, 0,          0,     0,          0,          2'b10, 32'hFFFF_FFFE, 1'b0, 0,       4,  1, 0, 0));

    rst = 1'b1; instr = '0; gpio_in = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      instr = tbl[i].instr; wb_we = tbl[i].we; wb_addr = tbl[i].wa;
      wb_data = tbl[i].wd; gpio_in = tbl[i].gpio;
      #1;
      check($sformatf("v%0d rs_data", i), rs_data, tbl[i].rs);
      check($sformatf("v%0d rt_data", i), rt_data, tbl[i].rt);
      if (tbl[i].chk[1]) check($sformatf("v%0d result", i), result, tbl[i].res);
      if (tbl[i].chk[0]) check($sformatf("v%0d zero", i), {31'h0, zero}, {31'h0, tbl[i].zero});
      check($sformatf("v%0d alu_hi", i), alu_hi, tbl[i].hi);
      check($sformatf("v%0d dest_addr", i), {27'h0, dest_addr}, {27'h0, tbl[i].dest});
      check($sformatf("v%0d regwrite", i), {31'h0, regwrite}, {31'h0, tbl[i].rw});
      check($sformatf("v%0d gpio_out_en", i), {31'h0, gpio_out_en}, {31'h0, tbl[i].goe});
      check($sformatf("v%0d gpio_in_en", i), {31'h0, gpio_in_en}, {31'h0, tbl[i].gie});
      check($sformatf("v%0d memwrite", i), {31'h0, memwrite}, 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a cycle with a write pending.
    instr = enc_r(1,0,0,0,6'h20); wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'h55;
    #1 check("pre-reset r1", rs_data, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1 check("async clear r1", rs_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; wb_we = 1'b0;
    instr = enc_r(20,0,0,0,6'h20);
    #1 check("discarded write r20", rs_data, 32'h0);
    instr = enc_r(0,0,4,0,6'h10);
    #1 check("hi after reset", result, 32'h0);
    instr = enc_r(0,0,4,0,6'h12);
    #1 check("lo after reset", result, 32'h0);
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'h55;
    @(negedge clk);
    wb_we = 1'b0; instr = enc_r(20,0,0,0,6'h20);
    #1 check("write after reset r20", rs_data, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
Name: mips_exec_unit

Overview:
- Execute-stage core of the two-stage MIPS pipeline: instruction decoder, 32x32 register file, 32-bit ALU with multiplier, and HI/LO registers.
- Takes the fetched instruction plus a writeback request from the pipeline register.
- Produces the operands, the writeback result, the destination address and the control strobes consumed by the CPU top.

Parameters:
- none (widths fixed: 32-bit data, 32 registers, 4-bit ALU op)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  32  instruction in EX
- gpio_in  in  32  GPIO input value
- wb_we  in  1  register-file write enable (from WB)
- wb_addr  in  5  write address
- wb_data  in  32  write data
- rs_data  out  32  regfile read, address instr[25:21]
- rt_data  out  32  regfile read, address instr[20:16]
- result  out  32  regsel-muxed writeback value
- alu_hi  out  32  ALU high result
- zero  out  1  ALU low result == 0
- regwrite  out  1  decoded register write
- dest_addr  out  5  rd (instr[15:11]) if rdrt=0, else rt (instr[20:16])
- memwrite  out  1  tied 0 (no stores)
- gpio_out_en  out  1  GPIO output strobe
- gpio_in_en  out  1  GPIO input select

Behaviour:
Register file
- 32x32 storage; asynchronous reset clears all entries.
- Write on posedge when wb_we=1 and wb_addr≠0; r0 always reads 0.
- Two combinational read ports with write-through bypass: if wb_we=1, wb_addr=read addr and wb_addr≠0, the read returns wb_data.

ALU operands
- a = rs_data.
- b selected by alu_src: 0 → rt_data; 1 → sign-extended instr[15:0]; 2 → zero-extended instr[15:0].

ALU op codes
- 0 AND, 1 OR, 2 XOR, 3 NOR.
- 4 ADD, 5 SUB; modulo 2^32, overflow ignored.
- 6 SLT (signed), 7 SLTU; lo = 1 or 0.
- 8 SLL, 9 SRL, A SRA: operate on b by shamt.
- B MULT (signed), C MULTU: {hi,lo} = 64-bit product.
- D–F: lo = 0.
- hi = 0 for every non-multiply op; zero = (lo == 0).

HI/LO registers
- Reset to 0.
- On posedge with enhilo=1 (mult/multu): HI←alu_hi, LO←ALU lo.

result mux (regsel)
- 0 → ALU lo
- 1 → HI reg
- 2 → LO reg
- 3 → gpio_in

Decode: opcode 0, by funct
- 20/21 add/addu → ADD
- 22/23 → SUB
- 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU
- 00/02/03 → SLL/SRL/SRA, shamt = instr[10:6]
- All of the above: regwrite=1, rdrt=0, alu_src=0, regsel=0.
- 18/19 mult/multu: enhilo=1, regwrite=0.
- 10 mfhi: regsel=1, regwrite=1; 12 mflo: regsel=2, regwrite=1.

Decode: I-type (rdrt=1, regwrite=1, regsel=0)
- 08/09 → ADD, sign-ext
- 0A → SLT, sign-ext; 0B → SLTU, sign-ext
- 0C/0D/0E → AND/OR/XOR, zero-ext
- 0F lui → SLL, shamt=16, zero-ext

Decode: GPIO and defaults
- opcode 1E (gpio read): regwrite=1, rdrt=1, regsel=3, gpio_in_en=1.
- opcode 1F (gpio write): gpio_out_en=1; the CPU latches rt_data.
- Unknown opcode/funct: all strobes 0 (NOP).
- Decoder is purely combinational; all outputs except HI/LO and regfile are combinational from instr and state.

Reset
- Mid-operation reset clears regfile and HI/LO immediately.
- Pending writes are discarded.

Decomposition:
- Package mips_pkg holds:
  - alu_op_e enum (4-bit codes above)
  - opcode and funct localparams
  - alu_src and regsel encodings
- One natural sub-module: mips_regfile (storage, bypass, r0 rule).
- ALU, decoder and HI/LO stay in the top.

Test Plan:
- Reset, then read all regs → rs_data=rt_data=0; HI/LO=0 (mfhi result 0).
- Same cycle: wb write r5=0xFFFF_FFF0; instr addi r6,r5,0x20 → rs_data shows bypass, result=0x0000_0010, dest=6, regwrite=1.
- Write r1=0xFFFFFFFF, r2=2:
  - mult r1,r2 then mfhi/mflo → 0xFFFFFFFF / 0xFFFFFFFE.
  - multu → 0x00000001 / 0xFFFFFFFE.
- r3=0x8000_0000: sra by 4 → 0xF800_0000; srl by 4 → 0x0800_0000; lui rt,0x1234 → 0x1234_0000; ori zero-ext 0xFFFF → 0x0000_FFFF.
- slt: r1(-1) vs r2(2) → 1; sltu → 0; sub r2,r2 → 0 and zero=1.
- Write attempt to r0 reads back 0.
- Opcode 1E with gpio_in=0xCAFE → result 0xCAFE, dest=rt.
- Opcode 1F → gpio_out_en=1.
- Unknown opcode 3B → regwrite=0, enhilo=0.
